// File: rtl/stream_compare_tracker.sv
// Streaming magnitude comparator with a one-entry output register, a debounced
// stable-relation tracker and saturating per-relation event counters.
module stream_compare_tracker #(
  parameter int WIDTH   = 8,
  parameter int SIGNED  = 0,
  parameter int PERSIST = 4,
  parameter int CNT_W   = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic             o_out_gt,
  output logic             o_out_lt,
  output logic             o_out_eq,
  input  logic             i_clr,
  output logic [1:0]       o_stable,
  output logic             o_stable_chg,
  output logic [CNT_W-1:0] o_cnt_gt,
  output logic [CNT_W-1:0] o_cnt_lt,
  output logic [CNT_W-1:0] o_cnt_eq
);

  typedef enum logic [1:0] {
    REL_UNK = 2'b00,
    REL_LT  = 2'b01,
    REL_EQ  = 2'b10,
    REL_GT  = 2'b11
  } rel_t;

  localparam int RUN_W = (PERSIST < 1) ? 1 : $clog2(PERSIST + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(PERSIST);

  logic             w_lt;
  logic             w_eq;
  logic             w_accept;
  rel_t             w_raw;
  logic [RUN_W-1:0] w_runNext;

  logic             r_outValid;
  logic             r_gt;
  logic             r_lt;
  logic             r_eq;
  rel_t             r_cand;
  rel_t             r_stable;
  logic [RUN_W-1:0] r_run;
  logic             r_stableChg;
  logic [CNT_W-1:0] r_cntGt;
  logic [CNT_W-1:0] r_cntLt;
  logic [CNT_W-1:0] r_cntEq;

  assign w_eq = (i_a == i_b);

  generate
    if (SIGNED != 0) begin : g_signed
      assign w_lt = ($signed(i_a) < $signed(i_b));
    end else begin : g_unsigned
      assign w_lt = (i_a < i_b);
    end
  endgenerate

  always_comb begin
    w_raw = REL_GT;
    if (w_eq) begin
      w_raw = REL_EQ;
    end else if (w_lt) begin
      w_raw = REL_LT;
    end
  end

  // Ready depends only on the output register, never on i_in_valid.
  assign o_in_ready = !i_rst && (!r_outValid || i_out_ready);
  assign w_accept   = i_in_valid && o_in_ready;

  always_comb begin
    w_runNext = RUN_W'(1);
    if (w_raw == r_cand) begin
      w_runNext = (r_run >= RUN_MAX) ? RUN_MAX : r_run + RUN_W'(1);
    end
  end

  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] c);
    return (c == '1) ? c : c + CNT_W'(1);
  endfunction

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_outValid  <= 1'b0;
      r_gt        <= 1'b0;
      r_lt        <= 1'b0;
      r_eq        <= 1'b0;
      r_cand      <= REL_UNK;
      r_stable    <= REL_UNK;
      r_run       <= '0;
      r_stableChg <= 1'b0;
      r_cntGt     <= '0;
      r_cntLt     <= '0;
      r_cntEq     <= '0;
    end else begin
      if (w_accept) begin
        r_outValid <= 1'b1;
        r_gt       <= (w_raw == REL_GT);
        r_lt       <= (w_raw == REL_LT);
        r_eq       <= (w_raw == REL_EQ);
      end else if (i_out_ready) begin
        r_outValid <= 1'b0;
      end

      // Clear wipes tracking state only; a concurrent sample still reaches the output stage.
      if (i_clr) begin
        r_cand      <= REL_UNK;
        r_stable    <= REL_UNK;
        r_run       <= '0;
        r_stableChg <= 1'b0;
        r_cntGt     <= '0;
        r_cntLt     <= '0;
        r_cntEq     <= '0;
      end else if (w_accept) begin
        r_cand <= w_raw;
        r_run  <= w_runNext;
        if ((w_runNext == RUN_MAX) && (r_stable != w_raw)) begin
          r_stable    <= w_raw;
          r_stableChg <= 1'b1;
        end else begin
          r_stableChg <= 1'b0;
        end
        case (w_raw)
          REL_GT:  r_cntGt <= satInc(r_cntGt);
          REL_LT:  r_cntLt <= satInc(r_cntLt);
          REL_EQ:  r_cntEq <= satInc(r_cntEq);
          default: ;
        endcase
      end else begin
        r_stableChg <= 1'b0;
      end
    end
  end

  assign o_out_valid  = r_outValid;
  assign o_out_gt     = r_gt;
  assign o_out_lt     = r_lt;
  assign o_out_eq     = r_eq;
  assign o_stable     = r_stable;
  assign o_stable_chg = r_stableChg;
  assign o_cnt_gt     = r_cntGt;
  assign o_cnt_lt     = r_cntLt;
  assign o_cnt_eq     = r_cntEq;

endmodule
